// File: rtl/stream_pkt_pkg.sv
// Shared types and header layout for the stream packetizer and its neighbours.
// The header word carries a magic tag, a sticky overflow flag and a 16-bit sequence number.
package stream_pkt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  localparam int HDR_W        = 32;
  localparam int HDR_MAGIC_HI = 31;
  localparam int HDR_MAGIC_LO = 24;
  localparam int HDR_OVF_BIT  = 23;
  localparam int HDR_SEQ_HI   = 15;
  localparam int HDR_SEQ_LO   = 0;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

  function automatic logic [HDR_W-1:0] make_header(input logic [7:0]  magic,
                                                   input logic        ovf,
                                                   input logic [15:0] seq);
    logic [HDR_W-1:0] h;
    h = '0;
    h[HDR_MAGIC_HI:HDR_MAGIC_LO] = magic;
    h[HDR_OVF_BIT]               = ovf;
    h[HDR_SEQ_HI:HDR_SEQ_LO]     = seq;
    return h;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO; dout always shows the head entry.
// Pushes on full and pops on empty are ignored; DEPTH must be a power of two.
module sync_fifo_fwft #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage is data only and carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/stream_packetizer.sv
// Buffers a non-backpressurable sample stream and frames it for the S2MM DMA:
// one header word, then up to PACKET_LEN payload words closed by tlast.
module stream_packetizer
  import stream_pkt_pkg::*;
#(
  parameter int         PACKET_LEN = 64,
  parameter int         FIFO_DEPTH = 256,
  parameter logic [7:0] MAGIC      = MAGIC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [31:0] drop_count,
  output logic [31:0] pkt_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = $clog2(PACKET_LEN + 1);
  localparam logic [WW-1:0] LAST_IDX = WW'(PACKET_LEN - 1);

  state_t           state;
  state_t           state_next;
  logic             ready_r;
  logic [15:0]      seq;
  logic             ovf;
  logic [HDR_W-1:0] hdr;
  logic [WW-1:0]    wcnt;
  logic [AW:0]      tlast_cnt;

  logic             fifo_full;
  logic             fifo_empty;
  logic [AW:0]      fifo_count;
  logic [32:0]      head;

  logic             in_word;
  logic             push;
  logic             drop;
  logic             pop;
  logic             capture;
  logic             start;
  logic             pkt_last;
  logic             hdr_hs;
  logic             last_hs;
  logic             tl_inc;
  logic             tl_dec;

  // Fullness is the registered count, so a push on a full FIFO drops even when a pop happens.
  assign in_word  = s_axis_tvalid && en;
  assign push     = in_word && !fifo_full;
  assign drop     = in_word && fifo_full;
  assign start    = (fifo_count >= (AW+1)'(PACKET_LEN)) || (tlast_cnt != '0);
  assign pkt_last = head[32] || (wcnt == LAST_IDX);
  assign hdr_hs   = (state == HEADER) && m_axis_tready;
  assign last_hs  = pop && pkt_last;
  assign tl_inc   = push && s_axis_tlast;
  assign tl_dec   = pop && !fifo_empty && head[32];

  assign s_axis_tready = ready_r;

  sync_fifo_fwft #(
    .WIDTH (33),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   ({s_axis_tlast, s_axis_tdata}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    capture       = 1'b0;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = HEADER;
          capture    = 1'b1;
        end
      end
      HEADER: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr;
        if (m_axis_tready) state_next = PAYLOAD;
      end
      PAYLOAD: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = head[31:0];
        m_axis_tlast  = pkt_last;
        if (m_axis_tready) begin
          pop = 1'b1;
          if (pkt_last) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Header word is data: captured on leaving IDLE, no reset needed.
  always_ff @(posedge clk) begin
    if (capture) hdr <= make_header(MAGIC, ovf, seq);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_r    <= 1'b0;
      seq        <= '0;
      ovf        <= 1'b0;
      wcnt       <= '0;
      tlast_cnt  <= '0;
      drop_count <= '0;
      pkt_count  <= '0;
    end else begin
      ready_r <= 1'b1;
      if (capture)   ovf <= drop;
      else if (drop) ovf <= 1'b1;
      if (drop && (drop_count != '1)) drop_count <= drop_count + 1'b1;
      if (hdr_hs) begin
        seq  <= seq + 1'b1;
        wcnt <= '0;
      end else if (pop) begin
        wcnt <= wcnt + 1'b1;
      end
      if (last_hs) pkt_count <= pkt_count + 1'b1;
      case ({tl_inc, tl_dec})
        2'b10:   tlast_cnt <= tlast_cnt + 1'b1;
        2'b01:   tlast_cnt <= tlast_cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule
